// File: rtl/usb_xfer_router.sv
// usb_xfer_router: steers word-level USB transfers to code RAM, video frame
// buffer, left/right sound FIFOs or the key/status snapshot reader. Tracks the
// active transfer type, generates word addresses and pulses per-destination
// done strobes when a full transfer has been moved.
module usb_xfer_router #(
  parameter int CODE_WORDS   = 4194304,
  parameter int VIDEO_WORDS  = 32768,
  parameter int SOUND_WORDS  = 4,
  parameter int STATUS_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   usb_trans_type,
  input  logic         usb_wr,
  input  logic [31:0]  usb_wr_data,
  output logic         usb_wr_ready,
  input  logic         usb_rd,
  output logic [31:0]  usb_rd_data,
  output logic         usb_rd_valid,
  output logic         usb_rd_ready,
  output logic         code_we,
  output logic [21:0]  code_addr,
  output logic [31:0]  code_wdata,
  input  logic         code_ready,
  output logic         vram_we,
  output logic [14:0]  vram_addr,
  output logic [31:0]  vram_wdata,
  input  logic         vram_ready,
  output logic         snd_l_valid,
  output logic         snd_r_valid,
  output logic [31:0]  snd_wdata,
  input  logic         snd_l_ready,
  input  logic         snd_r_ready,
  input  logic [255:0] status_in,
  output logic         code_done,
  output logic         vram_frame_done,
  output logic         snd_l_done,
  output logic         snd_r_done,
  output logic         status_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CODE   = 3'd1;
  localparam logic [2:0] S_VIDEO  = 3'd2;
  localparam logic [2:0] S_SND_L  = 3'd3;
  localparam logic [2:0] S_SND_R  = 3'd4;
  localparam logic [2:0] S_STATUS = 3'd5;

  localparam logic [21:0] CODE_LAST   = 22'(CODE_WORDS - 1);
  localparam logic [21:0] VIDEO_LAST  = 22'(VIDEO_WORDS - 1);
  localparam logic [21:0] SOUND_LAST  = 22'(SOUND_WORDS - 1);
  localparam logic [21:0] STATUS_LAST = 22'(STATUS_WORDS - 1);

  // Map the USB transfer-type code onto the internal state encoding.
  function automatic logic [2:0] decode_type(input logic [2:0] t);
    logic [2:0] s;
    case (t)
      3'd1:    s = S_CODE;
      3'd2:    s = S_VIDEO;
      3'd6:    s = S_SND_L;
      3'd5:    s = S_SND_R;
      3'd3:    s = S_STATUS;
      default: s = S_IDLE;
    endcase
    return s;
  endfunction

  logic [2:0]   state_q, state_d;
  logic [21:0]  word_cnt_q, word_cnt_d;
  logic [255:0] snap_q, snap_d;
  logic [4:0]   done_q, done_d;

  logic         match_s;
  logic         sel_code_s, sel_video_s, sel_snd_l_s, sel_snd_r_s, sel_status_s;
  logic [21:0]  last_s;
  logic         accept_s;
  logic         wrap_s;

  // Type decode, mismatch detection and per-destination select lines.
  always_comb begin
    state_d      = decode_type(usb_trans_type);
    match_s      = (state_d == state_q);
    sel_code_s   = match_s && (state_q == S_CODE);
    sel_video_s  = match_s && (state_q == S_VIDEO);
    sel_snd_l_s  = match_s && (state_q == S_SND_L);
    sel_snd_r_s  = match_s && (state_q == S_SND_R);
    sel_status_s = match_s && (state_q == S_STATUS);
    case (state_q)
      S_CODE:   last_s = CODE_LAST;
      S_VIDEO:  last_s = VIDEO_LAST;
      S_SND_L:  last_s = SOUND_LAST;
      S_SND_R:  last_s = SOUND_LAST;
      S_STATUS: last_s = STATUS_LAST;
      default:  last_s = 22'd0;
    endcase
  end

  // Zero-latency write path plus snapshot read path, gated by the select lines.
  always_comb begin
    usb_wr_ready = (sel_code_s  && code_ready)  ||
                   (sel_video_s && vram_ready)  ||
                   (sel_snd_l_s && snd_l_ready) ||
                   (sel_snd_r_s && snd_r_ready);
    usb_rd_valid = sel_status_s;
    usb_rd_ready = sel_status_s;

    code_we     = sel_code_s && usb_wr && code_ready;
    code_addr   = sel_code_s ? word_cnt_q : 22'd0;
    code_wdata  = sel_code_s ? usb_wr_data : 32'd0;

    vram_we     = sel_video_s && usb_wr && vram_ready;
    vram_addr   = sel_video_s ? word_cnt_q[14:0] : 15'd0;
    vram_wdata  = sel_video_s ? usb_wr_data : 32'd0;

    snd_l_valid = sel_snd_l_s && usb_wr && snd_l_ready;
    snd_r_valid = sel_snd_r_s && usb_wr && snd_r_ready;
    snd_wdata   = (sel_snd_l_s || sel_snd_r_s) ? usb_wr_data : 32'd0;

    if (sel_status_s) begin
      usb_rd_data = snap_q[{word_cnt_q[2:0], 5'd0} +: 32];
    end else begin
      usb_rd_data = 32'd0;
    end
  end

  // Word counter, wrap detection, snapshot capture and done-pulse next state.
  always_comb begin
    accept_s   = (usb_wr && usb_wr_ready) || (usb_rd && usb_rd_valid);
    wrap_s     = accept_s && (word_cnt_q == last_s);
    word_cnt_d = word_cnt_q;
    snap_d     = snap_q;
    done_d     = 5'd0;
    if (!match_s) begin
      word_cnt_d = 22'd0;
    end else if (wrap_s) begin
      word_cnt_d = 22'd0;
    end else if (accept_s) begin
      word_cnt_d = word_cnt_q + 22'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
    // Fresh coherent image on entry to STATUS and at the start of each repeat.
    if ((!match_s && (state_d == S_STATUS)) || (wrap_s && (state_q == S_STATUS))) begin
      snap_d = status_in;
    end else begin
      snap_d = snap_q;
    end
    if (wrap_s) begin
      done_d[0] = (state_q == S_CODE);
      done_d[1] = (state_q == S_VIDEO);
      done_d[2] = (state_q == S_SND_L);
      done_d[3] = (state_q == S_SND_R);
      done_d[4] = (state_q == S_STATUS);
    end else begin
      done_d = 5'd0;
    end
  end

  // State, counter, snapshot and done registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_cnt_q <= 22'd0;
      snap_q     <= 256'd0;
      done_q     <= 5'd0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      snap_q     <= snap_d;
      done_q     <= done_d;
    end
  end

  assign code_done       = done_q[0];
  assign vram_frame_done = done_q[1];
  assign snd_l_done      = done_q[2];
  assign snd_r_done      = done_q[3];
  assign status_done     = done_q[4];

endmodule

// File: tb/tb_usb_xfer_router.sv
// Self-checking bench for usb_xfer_router: scenario tasks with randomized data
// compared against a transfer-level model kept in the bench.
module tb_usb_xfer_router;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   usb_trans_type;
  logic         usb_wr;
  logic [31:0]  usb_wr_data;
  logic         usb_wr_ready;
  logic         usb_rd;
  logic [31:0]  usb_rd_data;
  logic         usb_rd_valid, usb_rd_ready;
  logic         code_we;
  logic [21:0]  code_addr;
  logic [31:0]  code_wdata;
  logic         code_ready;
  logic         vram_we;
  logic [14:0]  vram_addr;
  logic [31:0]  vram_wdata;
  logic         vram_ready;
  logic         snd_l_valid, snd_r_valid;
  logic [31:0]  snd_wdata;
  logic         snd_l_ready, snd_r_ready;
  logic [255:0] status_in;
  logic         code_done, vram_frame_done, snd_l_done, snd_r_done, status_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [176:0] all_out;
  assign all_out = {usb_wr_ready, usb_rd_data, usb_rd_valid, usb_rd_ready,
                    code_we, code_addr, code_wdata, vram_we, vram_addr, vram_wdata,
                    snd_l_valid, snd_r_valid, snd_wdata,
                    code_done, vram_frame_done, snd_l_done, snd_r_done, status_done};

  usb_xfer_router dut (
    .clk(clk), .rst(rst), .usb_trans_type(usb_trans_type),
    .usb_wr(usb_wr), .usb_wr_data(usb_wr_data), .usb_wr_ready(usb_wr_ready),
    .usb_rd(usb_rd), .usb_rd_data(usb_rd_data),
    .usb_rd_valid(usb_rd_valid), .usb_rd_ready(usb_rd_ready),
    .code_we(code_we), .code_addr(code_addr), .code_wdata(code_wdata), .code_ready(code_ready),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ready(vram_ready),
    .snd_l_valid(snd_l_valid), .snd_r_valid(snd_r_valid), .snd_wdata(snd_wdata),
    .snd_l_ready(snd_l_ready), .snd_r_ready(snd_r_ready),
    .status_in(status_in),
    .code_done(code_done), .vram_frame_done(vram_frame_done),
    .snd_l_done(snd_l_done), .snd_r_done(snd_r_done), .status_done(status_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; usb_trans_type = 3'd0; usb_wr = 1'b0; usb_wr_data = 32'd0; usb_rd = 1'b0;
    code_ready = 1'b1; vram_ready = 1'b1; snd_l_ready = 1'b1; snd_r_ready = 1'b1;
    status_in = 256'd0;
    tick(); tick();
    #1;
    total_cnt++;
    if (all_out !== 177'd0) $display("FAIL reset_outputs got %h want 0", all_out);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_video_frame();
    int bad = 0;
    logic [31:0] iv;
    usb_trans_type = 3'd2; usb_wr = 1'b0;
    #1;
    total_cnt++;
    if (usb_wr_ready !== 1'b0) $display("FAIL video_bubble_ready got %b want 0", usb_wr_ready);
    else pass_cnt++;
    tick();
    for (int i = 0; i < 32768; i++) begin
      iv = i;
      usb_wr = 1'b1; usb_wr_data = iv;
      #1;
      total_cnt++;
      if ({vram_we, vram_addr, vram_wdata, usb_wr_ready, vram_frame_done} !== {1'b1, iv[14:0], iv, 1'b1, 1'b0}) begin
        if (bad < 5) $display("FAIL video_word idx %0d got we=%b addr=%0d data=%h done=%b", i, vram_we, vram_addr, vram_wdata, vram_frame_done);
        bad++;
      end else pass_cnt++;
      tick();
    end
    usb_wr = 1'b0;
    #1;
    total_cnt++;
    if (vram_frame_done !== 1'b1) $display("FAIL video_done got %b want 1", vram_frame_done);
    else pass_cnt++;
    tick();
    usb_wr = 1'b1; usb_wr_data = 32'hCAFE_0000;
    #1;
    total_cnt++;
    if ({vram_frame_done, vram_we, vram_addr} !== {1'b0, 1'b1, 15'd0}) $display("FAIL video_restart got done=%b we=%b addr=%0d want 0/1/0", vram_frame_done, vram_we, vram_addr);
    else pass_cnt++;
    tick();
    usb_wr = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [31:0] words [4];
    int pushed = 0;
    int cyc = 0;
    logic rdy = 1'b1;
    for (int k = 0; k < 4; k++) words[k] = $urandom;
    usb_trans_type = 3'd6; usb_wr = 1'b0;
    tick();
    while (pushed < 4 && cyc < 50) begin
      snd_l_ready = rdy; usb_wr = 1'b1; usb_wr_data = words[pushed];
      #1;
      total_cnt++;
      if ({snd_l_valid, usb_wr_ready, snd_r_valid, snd_l_done, snd_wdata} !== {rdy, rdy, 1'b0, 1'b0, words[pushed]})
        $display("FAIL bp_cycle %0d got valid=%b ready=%b r=%b done=%b data=%h want %b/%b/0/0/%h",
                 cyc, snd_l_valid, usb_wr_ready, snd_r_valid, snd_l_done, snd_wdata, rdy, rdy, words[pushed]);
      else pass_cnt++;
      if (rdy) pushed++;
      rdy = ~rdy;
      cyc++;
      tick();
    end
    usb_wr = 1'b0; snd_l_ready = 1'b1;
    #1;
    total_cnt++;
    if ({pushed == 4, snd_l_done, snd_r_done} !== 3'b110) $display("FAIL bp_done got pushed=%0d done=%b rdone=%b want 4/1/0", pushed, snd_l_done, snd_r_done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (snd_l_done !== 1'b0) $display("FAIL bp_done_once got %b want 0", snd_l_done);
    else pass_cnt++;
  endtask

  task automatic test_status();
    logic [255:0] orig, newv;
    for (int i = 0; i < 8; i++) begin
      orig[32*i +: 32] = 32'h1000_0000 + i;
      newv[32*i +: 32] = 32'h2000_0000 + $urandom_range(0, 16'hFFFF);
    end
    status_in = orig; usb_trans_type = 3'd3; usb_rd = 1'b1;
    #1;
    total_cnt++;
    if ({usb_rd_valid, usb_rd_ready, usb_rd_data} !== {1'b0, 1'b0, 32'd0}) $display("FAIL status_bubble got valid=%b data=%h want 0", usb_rd_valid, usb_rd_data);
    else pass_cnt++;
    tick();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 8; k++) begin
        #1;
        total_cnt++;
        if ({usb_rd_valid, usb_rd_ready, status_done, usb_rd_data} !== {1'b1, 1'b1, 1'b0, (pass == 0) ? orig[32*k +: 32] : newv[32*k +: 32]})
          $display("FAIL status_read pass %0d word %0d got valid=%b done=%b data=%h", pass, k, usb_rd_valid, status_done, usb_rd_data);
        else pass_cnt++;
        tick();
        if (pass == 0 && k == 0) status_in = newv;
      end
      usb_rd = 1'b0;
      #1;
      total_cnt++;
      if (status_done !== 1'b1) $display("FAIL status_done pass %0d got %b want 1", pass, status_done);
      else pass_cnt++;
      tick();
      usb_rd = 1'b1;
    end
    usb_rd = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int bad = 0;
    usb_trans_type = 3'd1; usb_wr = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) begin
      d = $urandom; usb_wr = 1'b1; usb_wr_data = d;
      #1;
      total_cnt++;
      if ({code_we, code_addr, code_wdata} !== {1'b1, 22'(i), d}) begin
        if (bad < 5) $display("FAIL code_word idx %0d got we=%b addr=%0d data=%h", i, code_we, code_addr, code_wdata);
        bad++;
      end else pass_cnt++;
      tick();
    end
    usb_trans_type = 3'd2; usb_wr_data = 32'h5555_AAAA;
    #1;
    total_cnt++;
    if ({usb_wr_ready, code_we, vram_we, code_done} !== 4'b0000) $display("FAIL abort_bubble got rdy=%b cwe=%b vwe=%b cdone=%b want 0", usb_wr_ready, code_we, vram_we, code_done);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if ({code_done, vram_we, vram_addr, vram_wdata} !== {1'b0, 1'b1, 15'd0, 32'h5555_AAAA}) $display("FAIL abort_video_first got cdone=%b we=%b addr=%0d data=%h", code_done, vram_we, vram_addr, vram_wdata);
    else pass_cnt++;
    tick();
    usb_wr = 1'b0;
  endtask

  task automatic test_illegal();
    logic [2:0] tlist [3];
    tlist[0] = 3'd7; tlist[1] = 3'd4; tlist[2] = 3'd0;
    usb_wr = 1'b1; usb_rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      usb_trans_type = tlist[$urandom_range(0, 2)];
      if (i == 0) usb_trans_type = 3'd7;
      usb_wr_data = $urandom;
      #1;
      total_cnt++;
      if ({usb_wr_ready, usb_rd_valid, usb_rd_ready, code_we, vram_we, snd_l_valid, snd_r_valid, usb_rd_data} !== 39'd0)
        $display("FAIL illegal_type %0d cycle %0d got rdy=%b rv=%b cwe=%b vwe=%b", usb_trans_type, i, usb_wr_ready, usb_rd_valid, code_we, vram_we);
      else pass_cnt++;
      tick();
    end
    usb_wr = 1'b0; usb_rd = 1'b0;
  endtask

  task automatic test_random_sound_r();
    int acc = 0;
    logic exp_done = 1'b0;
    logic w, r;
    logic [31:0] d;
    usb_trans_type = 3'd5; usb_wr = 1'b0;
    tick();
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom); r = 1'($urandom); d = $urandom;
      usb_wr = w; snd_r_ready = r; usb_wr_data = d;
      #1;
      total_cnt++;
      if ({snd_r_valid, usb_wr_ready, snd_wdata, snd_r_done, snd_l_valid} !== {w & r, r, d, exp_done, 1'b0})
        $display("FAIL sndr_cycle %0d got v=%b rdy=%b data=%h done=%b want %b/%b/%h/%b", i, snd_r_valid, usb_wr_ready, snd_wdata, snd_r_done, w & r, r, d, exp_done);
      else pass_cnt++;
      if (w & r) begin
        acc++;
        exp_done = (acc % 4 == 0);
      end else exp_done = 1'b0;
      tick();
    end
    usb_wr = 1'b0; snd_r_ready = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    usb_trans_type = 3'd2; usb_wr = 1'b0;
    tick();
    for (int i = 0; i < 500; i++) begin
      usb_wr = 1'b1; usb_wr_data = $urandom;
      tick();
    end
    rst = 1'b1;
    tick();
    total_cnt++;
    if (all_out !== 177'd0) $display("FAIL reset_mid_outputs got %h want 0", all_out);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({usb_wr_ready, vram_we} !== 2'b00) $display("FAIL reset_mid_bubble got rdy=%b we=%b want 0", usb_wr_ready, vram_we);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({vram_we, vram_addr, vram_frame_done} !== {1'b1, 15'd0, 1'b0}) $display("FAIL reset_mid_restart got we=%b addr=%0d done=%b want 1/0/0", vram_we, vram_addr, vram_frame_done);
    else pass_cnt++;
    tick();
    usb_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_video_frame();
    test_back_pressure();
    test_status();
    test_abort();
    test_illegal();
    test_random_sound_r();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/usb_xfer_router.md
# usb_xfer_router

Transfer-side controller for the FX3 USB bridge. It sits on the mux side of `mux_usb_interface` and steers each word-level USB transfer to one destination: code RAM, the video frame buffer, the left or right sound FIFO, or the key/status snapshot source. It tracks the current transfer type and generates word addresses. It also gates ready/valid on the selected endpoint and pulses a per-destination done strobe when a full transfer completes.

## Interface
Parameters:
- CODE_WORDS, 4194304: words per code transfer (16 MiB).
- VIDEO_WORDS, 32768: words per video frame (128 KiB).
- SOUND_WORDS, 4: words per left/right sound frame (16 B).
- STATUS_WORDS, 8: words per key/status transfer (32 B).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; synchronous and active-high.
- usb_trans_type  in  3  current type: 0 none, 1 code, 2 video, 6 sound L, 5 sound R, 3 key/status; other values are treated as none.
- usb_wr / usb_wr_data  in  1/32  write strobe and data from USB (PC→FPGA).
- usb_wr_ready  out  1  router accepts a write this cycle.
- usb_rd  in  1  read strobe from USB (FPGA→PC).
- usb_rd_data  out  32  read data.
- usb_rd_valid, usb_rd_ready  out  1  read word available.
- code_we / code_addr / code_wdata / code_ready  out/out/out/in  1/22/32/1  code RAM write port.
- vram_we / vram_addr / vram_wdata / vram_ready  out/out/out/in  1/15/32/1  frame-buffer write port.
- snd_l_valid, snd_r_valid / snd_wdata / snd_l_ready, snd_r_ready  out/out/in  1,1/32/1,1  sound FIFO pushes.
- status_in  in  256  live key/status words; word i = bits [32i+31:32i].
- code_done, vram_frame_done, snd_l_done, snd_r_done, status_done  out  1  one-cycle completion pulses.

## Operation
- State register, one per type: IDLE, CODE, VIDEO, SND_L, SND_R, STATUS. Each cycle the state is loaded from the decode of usb_trans_type.
- Type mismatch: the cycle in which usb_trans_type differs from the state is a mismatch. During a mismatch the router does the following:
  - forces ready/valid low;
  - clears word_cnt to 0;
  - fires no done pulse.
- Mid-transfer type change is an abort: counter cleared, no done pulse, and any partial data already written stays.
- word_cnt (22-bit):
  - increments on each usb_wr or usb_rd accepted in a matching state;
  - wraps to 0 after SIZE-1, where SIZE is the state's words parameter;
  - the wrap cycle asserts that state's done pulse on the next cycle.
  - Because of the wrap, reissuing the same type restarts cleanly at address 0.
- Write path is combinational, zero latency:
  - usb_wr_ready = matching write state & selected sink ready.
  - CODE: code_we = usb_wr, code_addr = word_cnt[21:0], code_wdata = usb_wr_data.
  - VIDEO: vram_we, vram_addr = word_cnt[14:0], vram_wdata likewise.
  - SND_L / SND_R: snd_l_valid / snd_r_valid = usb_wr, snd_wdata = usb_wr_data.
  - Sink strobes not selected are held 0. The *_wdata outputs are 0 when not selected.
- Read path:
  - STATUS latches a 256-bit snapshot of status_in on entry (the mismatch cycle into STATUS) and again on each wrap.
  - usb_rd_valid = usb_rd_ready = matching STATUS. usb_rd_data = snapshot word word_cnt[2:0], otherwise 0.
  - The snapshot gives the PC a coherent 8-word image.
- usb_wr while not ready, and usb_rd while not valid, are ignored: no counter change, no sink strobe.

## Timing
- Reset values: state IDLE, word_cnt 0, snapshot 0, all outputs 0.
- Type change costs exactly one bubble cycle (the mismatch). The first word can transfer in the following cycle.
- Write latency is 0: the sink strobe is in the same cycle as usb_wr. Read data is valid in the same cycle as usb_rd_valid.
- Done pulses are registered: high in the cycle after the last accepted word, for one cycle.
- Sink back-pressure: when the sink's ready is 0, usb_wr_ready is 0 in that same cycle and the counter holds.
- Reset mid-transfer: on the next edge everything returns to reset values; partial transfer abandoned, no done pulse.

## Test plan
- Video frame: type 2, stream 32768 words with value = index. Required response:
  - vram_addr 0..32767, data matches;
  - vram_frame_done high once, the cycle after word 32767;
  - word_cnt back to 0.
- Back-pressure: type 6, 4 words, snd_l_ready toggled 1/0 every cycle → exactly 4 snd_l_valid pushes with correct order, then snd_l_done once; snd_r_valid stays 0.
- Status snapshot: status_in = words 0x1000_0000+i, enter type 3, change status_in after the first read, read 8 words → data equals the original values, then status_done. A second type-3 transfer returns the new values.
- Abort: type 1, write 100 words, switch to type 2 → no code_done; the next video write goes to vram_addr 0 after one bubble cycle.
- Bubble and illegal type: on the change cycle usb_wr_ready is 0 and writes are ignored. Type 7 → IDLE, ready/valid remain 0.
- Reset mid-frame: rst high after 500 video words → all outputs 0 next cycle; after release with type 2, vram_addr restarts at 0.
